// File: rtl/pipe_muldiv_unit.sv
// pipe_muldiv_unit: iterative mult/multu/div/divu into HI/LO with stall, mthi/mtlo and flush.
// Define MULDIV_FAST_MUL_EN to compute products in one cycle (IDLE->FIX); division stays iterative.
module pipe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic is_div_q, is_div_d, neg_q, neg_d, sa_q, sa_d;
  logic accept, sgn, sa, sb, in_busy;
  logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    in_busy  = (state_q == CALC) || (state_q == FIX);
    accept   = start && !in_busy;
    sgn      = ~op[0];
    sa       = sgn & a[WIDTH-1];
    sb       = sgn & b[WIDTH-1];
    abs_a    = sa ? -a : a;
    abs_b    = sb ? -b : b;
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb_q};
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
    // A zero divisor leaves the remainder equal to |a|, so the sign fix restores HI=a.
    quo_fix  = (opb_q == '0) ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;
    case (state_q)
      CALC: begin
        if (flush) state_d = IDLE;
        else begin
          if (is_div_q) begin
            acc_hi_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
          end
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
        end
      end
      FIX: begin
        if (flush) state_d = IDLE;
        else begin
          hi_d    = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!in_busy) begin
      hi_d = hi_we ? wdata : hi_d;
      lo_d = lo_we ? wdata : lo_d;
    end
    if (accept) begin
      is_div_d = op[1];
      neg_d    = sa ^ sb;
      sa_d     = sa;
      cnt_d    = '0;
      acc_hi_d = '0;
      acc_lo_d = op[1] ? abs_a : abs_b;
      opb_d    = op[1] ? abs_b : abs_a;
      state_d  = CALC;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) begin
        {acc_hi_d, acc_lo_d} = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
        state_d = FIX;
      end
`endif
    end
  end
  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = state_q == DONE;
    hi   = hi_q;
    lo   = lo_q;
  end
endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// tb_pipe_muldiv_unit: scoreboard bench with a plain-arithmetic reference model.
module tb_pipe_muldiv_unit;
  logic clk = 0, rst = 0, start = 0, hi_we = 0, lo_we = 0, flush = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int cyc = 0, tests = 0, fails = 0;
  logic [31:0] model_hi = 0, model_lo = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef struct {logic [31:0] hi; logic [31:0] lo; int e0; int lat;} exp_t;
  exp_t sbq[$];

  pipe_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int q, r;
    case (o)
      2'd0: begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      2'd1: begin p = longint'({32'b0, x}) * longint'({32'b0, y}); return p; end
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && busy && done) begin
      tests++; fails++;
      $display("FAIL busy_and_done: both high at cycle %0d", cyc);
    end
    if (rst && done) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e.hi});
        chk("lo", {32'b0, lo}, {32'b0, e.lo});
        chk("latency", 64'(cyc - e.e0), 64'(e.lat));
        model_hi = e.hi;
        model_lo = e.lo;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    logic [63:0] r;
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    if (push) begin
      r = model(o, x, y);
      sbq.push_back('{r[63:32], r[31:0], cyc, (!o[1] && FAST) ? 1 : 33});
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (sbq.size() == 0 && !busy && !done) return;
    end
    tests++; fails++;
    $display("FAIL timeout: got %0d pending expected 0", sbq.size());
    sbq.delete();
  endtask

  task automatic write_hl(input logic h, input logic [31:0] d);
    @(negedge clk);
    hi_we = h; lo_we = !h; wdata = d;
    @(negedge clk);
    hi_we = 0; lo_we = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    rst = 1;
    issue(2'd1, 32'hFFFFFFFF, 32'd2, 1); wait_idle();
    issue(2'd0, 32'hFFFFFFFD, 32'd5, 1); wait_idle();
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 1); wait_idle();
    issue(2'd3, 32'd7, 32'd0, 1); wait_idle();
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1); wait_idle();
    issue(2'd2, 32'hFFFFFFF9, 32'd0, 1); wait_idle();
    // Second start three cycles into a divide is ignored.
    issue(2'd3, 32'd1000, 32'd7, 1);
    repeat (2) @(negedge clk);
    start = 1; op = 2'd0; a = 32'h12345678; b = 32'h9;
    @(negedge clk);
    start = 0;
    wait_idle();
    // Preload, then flush a divide mid-flight.
    write_hl(1, 32'h1234);
    write_hl(0, 32'h5678);
    model_hi = 32'h1234; model_lo = 32'h5678;
    chk("preload_hi", {32'b0, hi}, 64'h1234);
    chk("preload_lo", {32'b0, lo}, 64'h5678);
    issue(2'd2, 32'd100, 32'd3, 0);
    repeat (4) @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hi", {32'b0, hi}, {32'b0, model_hi});
    chk("flush_lo", {32'b0, lo}, {32'b0, model_lo});
    @(negedge clk);
    flush = 0;
    repeat (40) @(negedge clk);
    // mthi while busy is ignored.
    issue(2'd1, 32'd3, 32'd5, 1);
    hi_we = 1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 0; #1;
    chk("busy_write_hi", {32'b0, hi}, {32'b0, model_hi});
    wait_idle();
    // Reset in the middle of CALC.
    issue(2'd3, 32'hFFFF0000, 32'd13, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_hi", {32'b0, hi}, 64'd0);
    chk("midrst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    rst = 1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] x, y;
      x = (i % 3 == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      y = (i % 7 == 0) ? 32'd0 : (i % 3 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 5 == 4) y = -y;
      issue(2'($urandom_range(0, 3)), x, y, 1);
      wait_idle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
